// File: rtl/wb_sram_port0_bridge.sv
// Wishbone slave driving RW port 0 of a 32x256 OpenRAM SRAM macro.
// Every macro and bus output is registered; one access is handled at a time.
module wb_sram_port0_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_WMASKS = 4,
  parameter int          READ_WAIT  = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_ACK, S_ERR} state_t;

  localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_WIDTH;

  state_t                r_state, w_state_nxt;
  logic                  r_csb, r_web, r_ack, r_err;
  logic [NUM_WMASKS-1:0] r_wmask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din, r_dat;
  logic [2:0]            r_cnt;

  logic                  w_csb, w_web, w_ack, w_err;
  logic [NUM_WMASKS-1:0] w_wmask;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din, w_dat;
  logic [2:0]            w_cnt;
  logic [31:0]           w_off;
  logic                  w_hit, w_req;

  // Unsigned wrap-around makes addresses below BASE_ADDR land far outside the window.
  assign w_off = wbs_adr_i - BASE_ADDR;
  assign w_hit = (w_off < WIN_BYTES);
  assign w_req = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_csb       = r_csb;
    w_web       = r_web;
    w_wmask     = r_wmask;
    w_addr      = r_addr;
    w_din       = r_din;
    w_dat       = r_dat;
    w_cnt       = r_cnt;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_state_nxt = S_ISSUE;
            w_csb       = 1'b0;
            w_web       = ~wbs_we_i;
            w_wmask     = wbs_we_i ? wbs_sel_i : '0;
            w_addr      = wbs_adr_i[ADDR_WIDTH+1:2];
            w_din       = wbs_dat_i;
          end else begin
            w_state_nxt = S_ERR;
            w_err       = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // r_web still holds the direction of the access the macro samples now.
        w_csb   = 1'b1;
        w_web   = 1'b1;
        w_wmask = '0;
        if (!r_web) begin
          w_state_nxt = S_ACK;
          w_ack       = 1'b1;
        end else begin
          w_state_nxt = S_RDWAIT;
          w_cnt       = 3'(READ_WAIT);
        end
      end
      S_RDWAIT: begin
        if (r_cnt == 3'd0) begin
          w_dat       = sram_dout0;
          w_state_nxt = S_ACK;
          w_ack       = 1'b1;
        end else begin
          w_cnt = r_cnt - 3'd1;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dat   <= '0;
      r_cnt   <= 3'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_csb   <= w_csb;
      r_web   <= w_web;
      r_wmask <= w_wmask;
      r_addr  <= w_addr;
      r_din   <= w_din;
      r_dat   <= w_dat;
      r_cnt   <= w_cnt;
      r_ack   <= w_ack;
      r_err   <= w_err;
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_err_o   = r_err;
  assign wbs_dat_o   = r_dat;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;

endmodule
